// File: rtl/blink_stretch_pkg.sv
// blink_stretch_pkg: clock-rate constant and a cycle helper used to size
// the blink timing parameters. Shared with the key input conditioner.
package blink_stretch_pkg;

    // System clock rate of the LED/key clock domain.
    localparam int unsigned CLK_HZ = 100_000_000;

    // Converts a duration in milliseconds to clk cycles.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/blink_stretch_if.sv
// blink_stretch_if: event in / LED-side status out for blink_stretch.
// Optional macro BLINK_DROP_CNT_EN adds the drop_o counter signal.
interface blink_stretch_if #(
    parameter int unsigned QBITS = 4
);
    logic             evt_i;
    logic             led_o;
    logic             busy_o;
    logic [QBITS-1:0] pend_o;
`ifdef BLINK_DROP_CNT_EN
    logic [7:0]       drop_o;

    modport master (output evt_i, input led_o, busy_o, pend_o, drop_o);
    modport slave  (input evt_i, output led_o, busy_o, pend_o, drop_o);
`else
    modport master (output evt_i, input led_o, busy_o, pend_o);
    modport slave  (input evt_i, output led_o, busy_o, pend_o);
`endif
endinterface

// File: rtl/blink_stretch_evt_edge.sv
// blink_stretch_evt_edge: rising-edge detector for an already-synchronous
// level. The history flop clears on reset, so a level held high through
// reset shows up as a rise on the first cycle after release.
module blink_stretch_evt_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_evt,
    output logic o_rise
);
    logic r_evt_q;

    // Previous-cycle copy of the event level.
    always_ff @(posedge clk) begin
        if (rst) r_evt_q <= 1'b0;
        else     r_evt_q <= i_evt;
    end

    assign o_rise = i_evt & ~r_evt_q;
endmodule

// File: rtl/blink_stretch.sv
// blink_stretch: turns event rises into human-visible LED blinks
// (HOLD cycles on, then at least GAP cycles off). Rises that arrive while
// a blink runs are queued in a saturating counter and replayed.
// Optional macro BLINK_DROP_CNT_EN adds drop_o, a saturating count of
// events lost at queue saturation.
module blink_stretch
    import blink_stretch_pkg::*;
#(
    parameter int unsigned HOLD  = ms_to_cycles(50),
    parameter int unsigned GAP   = ms_to_cycles(50),
    parameter int unsigned NBITS = 24,
    parameter int unsigned QBITS = 4
) (
    input  logic           clk,
    input  logic           rst,
    blink_stretch_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [NBITS-1:0] HOLD_END = NBITS'(HOLD - 1);
    localparam logic [NBITS-1:0] GAP_END  = NBITS'(GAP - 1);
    localparam logic [QBITS-1:0] PEND_MAX = '1;

    state_t           r_state, w_state_nxt;
    logic [NBITS-1:0] r_cnt, w_cnt_nxt;
    logic [QBITS-1:0] r_pend, w_pend_nxt;
    logic             r_led, w_led_nxt;
    logic             w_rise;
    logic             w_hold_done;
    logic             w_gap_done;

    blink_stretch_evt_edge u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_evt  (bus.evt_i),
        .o_rise (w_rise)
    );

    assign w_hold_done = (r_state == ST_ON)  && (r_cnt == HOLD_END);
    assign w_gap_done  = (r_state == ST_OFF) && (r_cnt == GAP_END);

    // State, timer, queue and LED registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_led   <= w_led_nxt;
        end
    end

    // Next state: a rise coinciding with the end of the gap restarts ON
    // directly, so it is never lost to a pass through IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_rise)      w_state_nxt = ST_ON;
            ST_ON:   if (w_hold_done) w_state_nxt = ST_OFF;
            ST_OFF:  if (w_gap_done)
                         w_state_nxt = (r_pend != '0 || w_rise) ? ST_ON : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next timer/queue/LED values. The timer restarts on every state change
    // and is held at zero in IDLE; a rise during a replay cancels the
    // replay's decrement so the queue depth is unchanged.
    always_comb begin
        w_cnt_nxt  = r_cnt + 1'b1;
        w_pend_nxt = r_pend;
        w_led_nxt  = (w_state_nxt == ST_ON);
        if (r_state == ST_IDLE || w_state_nxt != r_state)
            w_cnt_nxt = '0;
        if (w_gap_done) begin
            if (!w_rise && r_pend != '0)
                w_pend_nxt = r_pend - 1'b1;
        end else if (r_state != ST_IDLE && w_rise && r_pend != PEND_MAX) begin
            w_pend_nxt = r_pend + 1'b1;
        end
    end

    assign bus.led_o  = r_led;
    assign bus.busy_o = (r_state != ST_IDLE);
    assign bus.pend_o = r_pend;

`ifdef BLINK_DROP_CNT_EN
    logic       w_drop;
    logic [7:0] r_drop;

    // A rise is lost only when queued at saturation outside a replay cycle.
    assign w_drop = w_rise && (r_pend == PEND_MAX) &&
                    (r_state == ST_ON || (r_state == ST_OFF && !w_gap_done));

    // Saturating count of lost events.
    always_ff @(posedge clk) begin
        if (rst)                          r_drop <= '0;
        else if (w_drop && r_drop != '1)  r_drop <= r_drop + 8'd1;
    end

    assign bus.drop_o = r_drop;
`endif
endmodule
